expr_ctrl: RTL and testbench

Streaming expression sequencer and evaluator that sits in front of the `expr` checker path. It accepts ASCII characters one per handshake, checks the grammar `digit ((+|*) digit)* =`, and evaluates the expression with `*` taking precedence over `+`. It returns one result per `=` terminator through a held valid/ready output handshake, and applies backpressure to the character source while a result is pending.

---
 rtl/expr_ctrl.sv | 153 +++++++++++++++
 tb/tb_expr_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/expr_ctrl.sv
// rtl/expr_ctrl.sv - streaming digit/operator expression sequencer and evaluator
//
// Accepts ASCII characters one per in_valid/in_ready handshake. It checks the
// grammar digit ((+|*) digit)* = and evaluates it with '*' binding tighter
// than '+'. One result is returned per '=' through a held res_valid/res_ready
// handshake. No further characters are accepted while that result is pending.
//
// Ports:
//   clk        in   clock, rising edge
//   clr        in   asynchronous active-low reset
//   in         in   [7:0] ASCII character
//   in_valid   in   character valid
//   in_ready   out  block can accept a character (low only while a result is pending)
//   res        out  [WIDTH-1:0] expression value, 0 on error
//   err        out  grammar error flag, qualified by res_valid
//   res_valid  out  res/err hold a result
//   res_ready  in   consumer takes the result

module expr_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             clr,
   input  logic [7:0]       in,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] res,
   output logic             err,
   output logic             res_valid,
   input  logic             res_ready
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   typedef enum logic [1:0] {
      EXP_D = 2'd0,   // expecting a digit
      OPND  = 2'd1,   // operand seen, expecting an operator or '='
      ERR   = 2'd2,   // grammar broken, discard until '='
      DONE  = 2'd3    // result held on the output
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_s;       // sum of completed terms
   logic [WIDTH-1:0] r_p;       // product of the current term
   logic [WIDTH-1:0] r_res;
   logic             r_err;
   logic [WIDTH-1:0] w_s_nxt;
   logic [WIDTH-1:0] w_p_nxt;
   logic [WIDTH-1:0] w_res_nxt;
   logic             w_err_nxt;

   logic             w_accept;
   logic             w_is_digit;
   logic             w_is_plus;
   logic             w_is_mul;
   logic             w_is_eq;
   logic [WIDTH-1:0] w_digit;
   logic [WIDTH-1:0] w_prod;
   logic [WIDTH-1:0] w_sum;

   assign w_accept   = in_valid & in_ready;
   assign w_is_digit = (in >= 8'h30) && (in <= 8'h39);
   assign w_is_plus  = (in == 8'h2B);
   assign w_is_mul   = (in == 8'h2A);
   assign w_is_eq    = (in == 8'h3D);
   assign w_digit    = {{(WIDTH-4){1'b0}}, in[3:0]};
   // Both results wrap to WIDTH bits on every step.
   assign w_prod     = r_p * w_digit;
   assign w_sum      = r_s + r_p;

   assign in_ready   = (r_state != DONE);
   assign res_valid  = (r_state == DONE);
   assign res        = r_res;
   assign err        = r_err;

   always_comb begin
      w_state_nxt = r_state;
      w_s_nxt     = r_s;
      w_p_nxt     = r_p;
      w_res_nxt   = r_res;
      w_err_nxt   = r_err;
      case (r_state)
         EXP_D: begin
            if (w_accept) begin
               if (w_is_digit) begin
                  w_state_nxt = OPND;
                  w_p_nxt     = w_prod;
               end else if (w_is_eq) begin
                  w_state_nxt = DONE;
                  w_res_nxt   = '0;
                  w_err_nxt   = 1'b1;
               end else begin
                  w_state_nxt = ERR;
               end
            end
         end
         OPND: begin
            if (w_accept) begin
               if (w_is_plus) begin
                  w_state_nxt = EXP_D;
                  w_s_nxt     = w_sum;
                  w_p_nxt     = ONE;
               end else if (w_is_mul) begin
                  w_state_nxt = EXP_D;
               end else if (w_is_eq) begin
                  w_state_nxt = DONE;
                  w_res_nxt   = w_sum;
                  w_err_nxt   = 1'b0;
               end else begin
                  // A second consecutive digit lands here: multi-digit operands are illegal.
                  w_state_nxt = ERR;
               end
            end
         end
         ERR: begin
            if (w_accept && w_is_eq) begin
               w_state_nxt = DONE;
               w_res_nxt   = '0;
               w_err_nxt   = 1'b1;
            end
         end
         DONE: begin
            // res_valid is 1 here, so res_ready alone completes the handshake.
            if (res_ready) begin
               w_state_nxt = EXP_D;
               w_s_nxt     = '0;
               w_p_nxt     = ONE;
            end
         end
         default: begin
            w_state_nxt = EXP_D;
         end
      endcase
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_state <= EXP_D;
         r_s     <= '0;
         r_p     <= ONE;
         r_res   <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_s     <= w_s_nxt;
         r_p     <= w_p_nxt;
         r_res   <= w_res_nxt;
         r_err   <= w_err_nxt;
      end
   end

endmodule

// File: tb/tb_expr_ctrl.sv
// tb/tb_expr_ctrl.sv - directed self-checking bench for expr_ctrl

module tb_expr_ctrl;

   localparam int W = 8;

   logic         clk;
   logic         clr;
   logic [7:0]   in;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] res;
   logic         err;
   logic         res_valid;
   logic         res_ready;

   int vectors;
   int miscompares;

   expr_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .clr       (clr),
      .in        (in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .res       (res),
      .err       (err),
      .res_valid (res_valid),
      .res_ready (res_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Called at a negedge; presents c, waits for in_ready, and returns at the
   // negedge following the accepting posedge.
   task automatic send(input logic [7:0] c);
      int n;
      in       = c;
      in_valid = 1'b1;
      n        = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) check("send_ready", 32'(in_ready), 1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send(s[i]);
   endtask

   // Called at the negedge right after '=' was accepted with res_ready=1.
   task automatic check_result(input string tag, input int exp_res, input int exp_err);
      check({tag, "_valid"}, 32'(res_valid), 1);
      check({tag, "_res"},   32'(res),       32'(exp_res));
      check({tag, "_err"},   32'(err),       32'(exp_err));
      @(negedge clk);
      check({tag, "_valid_drop"}, 32'(res_valid), 0);
      check({tag, "_in_ready"},   32'(in_ready),  1);
   endtask

   task automatic run(input string s, input int exp_res, input int exp_err);
      res_ready = 1'b1;
      send_str(s);
      check_result(s, exp_res, exp_err);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      clr         = 1'b0;
      in          = 8'h00;
      in_valid    = 1'b0;
      res_ready   = 1'b0;

      #2;
      check("rst_in_ready",  32'(in_ready),  1);
      check("rst_res_valid", 32'(res_valid), 0);
      check("rst_res",       32'(res),       0);
      check("rst_err",       32'(err),       0);
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);

      // Precedence
      run("1+2*3=",   7,  0);
      run("2*3*4+5=", 29, 0);

      // Grammar errors, then recovery
      run("1+*2=", 0, 1);
      run("=",     0, 1);
      run("12=",   0, 1);
      run("1+2=",  3, 0);

      // Backpressure: '9' held on the input while the result stalls
      res_ready = 1'b0;
      send_str("4*5=");
      in       = "9";
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check("bp_in_ready",  32'(in_ready),  0);
         check("bp_res_valid", 32'(res_valid), 1);
         check("bp_res",       32'(res),       20);
         check("bp_err",       32'(err),       0);
         @(negedge clk);
      end
      res_ready = 1'b1;
      @(negedge clk);
      check("bp_hs_valid",    32'(res_valid), 0);
      check("bp_hs_in_ready", 32'(in_ready),  1);
      @(negedge clk);
      in_valid = 1'b0;
      send("=");
      check_result("bp_9", 9, 0);

      // Wraparound at WIDTH=8
      run("9*9*9=",       217, 0);
      run("9*9*9+100=",   0,   1);
      run("9*9*9+4*5*5=", 61,  0);

      // Asynchronous reset mid-expression
      send_str("1+2");
      #2 clr = 1'b0;
      #1;
      check("rst_mid_in_ready",  32'(in_ready),  1);
      check("rst_mid_res_valid", 32'(res_valid), 0);
      check("rst_mid_res",       32'(res),       0);
      check("rst_mid_err",       32'(err),       0);
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      run("4=", 4, 0);

      // Asynchronous reset while a result is pending
      res_ready = 1'b0;
      send_str("5=");
      check("pend_valid", 32'(res_valid), 1);
      #2 clr = 1'b0;
      #1;
      check("rst_done_res_valid", 32'(res_valid), 0);
      check("rst_done_in_ready",  32'(in_ready),  1);
      check("rst_done_res",       32'(res),       0);
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      run("1+2=", 3, 0);

      // Idle gaps between characters
      res_ready = 1'b1;
      send("3");
      repeat (2) @(negedge clk);
      send("*");
      repeat (2) @(negedge clk);
      send("3");
      repeat (2) @(negedge clk);
      check("gap_no_result", 32'(res_valid), 0);
      send("=");
      check_result("gap", 9, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
